// File: rtl/pkt_bufid_release.sv
// Buffer-id release engine: per-bufid reference counts, round-robin release arbitration, free-list handoff.
// Build option PKT_REFCNT_ERR_EN: a release of a zero-count bufid is flagged instead of freeing it.

module pkt_bufid_release #(
  parameter int REFCNT_W = 4,
  parameter int PORT_NUM = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [8:0]            iv_refcnt_bufid,
  input  logic [REFCNT_W-1:0]   iv_refcnt_value,
  input  logic                  i_refcnt_wr,
  input  logic [9*PORT_NUM-1:0] iv_rel_bufid,
  input  logic [PORT_NUM-1:0]   iv_rel_bufid_wr,
  output logic [PORT_NUM-1:0]   ov_rel_bufid_ack,
  output logic [8:0]            ov_free_bufid,
  output logic                  o_free_bufid_wr,
  input  logic                  i_free_bufid_ack,
  output logic                  o_refcnt_err_pulse,
  output logic [1:0]            ov_rel_state
);

  localparam logic [REFCNT_W-1:0] CNT_ONE = {{(REFCNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEC  = 2'd1,
    ST_FREE = 2'd2,
    ST_RSVD = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [REFCNT_W-1:0]   cnt_r [512];
  logic [1:0]            last_r;
  logic [1:0]            port_r;
  logic [8:0]            bufid_r;
  logic [PORT_NUM-1:0]   ack_r;
  logic [PORT_NUM-1:0]   ack_nxt_s;
  logic [8:0]            free_bufid_r;
  logic [8:0]            free_bufid_nxt_s;
  logic                  free_wr_r;
  logic                  free_wr_nxt_s;
  logic                  err_r;
  logic                  err_nxt_s;
  logic [PORT_NUM-1:0]   req_s;
  logic                  grant_vld_s;
  logic [1:0]            grant_port_s;
  logic [5:0]            sel_base_s;
  logic                  latch_s;
  logic                  cnt_we_s;
  logic [REFCNT_W-1:0]   cnt_wval_s;
  logic [REFCNT_W-1:0]   cur_cnt_s;
  logic                  stall_s;

  assign cur_cnt_s  = cnt_r[bufid_r];
  assign stall_s    = i_refcnt_wr && (iv_refcnt_bufid == bufid_r);
  assign sel_base_s = {1'b0, grant_port_s, 3'b000} + {4'b0000, grant_port_s};

  // Round-robin pick starting one past the last grant; the port being acked this cycle is skipped
  // so its still-high request line is not mistaken for a new request.
  always_comb begin
    logic [1:0] cand_s;
    req_s        = iv_rel_bufid_wr & ~ack_r;
    grant_vld_s  = 1'b0;
    grant_port_s = last_r;
    cand_s       = last_r;
    for (int i = 1; i <= PORT_NUM; i++) begin
      cand_s = last_r + 2'(i);
      if (!grant_vld_s && req_s[cand_s]) begin
        grant_vld_s  = 1'b1;
        grant_port_s = cand_s;
      end else begin
        cand_s = cand_s;
      end
    end
  end

  // Next-state and next-output decode for the release FSM.
  always_comb begin
    state_nxt_s      = state_r;
    latch_s          = 1'b0;
    cnt_we_s         = 1'b0;
    cnt_wval_s       = {REFCNT_W{1'b0}};
    ack_nxt_s        = {PORT_NUM{1'b0}};
    err_nxt_s        = 1'b0;
    free_wr_nxt_s    = free_wr_r;
    free_bufid_nxt_s = free_bufid_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_vld_s) begin
          latch_s     = 1'b1;
          state_nxt_s = ST_DEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DEC: begin
        if (stall_s) begin
          state_nxt_s = ST_DEC;
        end else if (cur_cnt_s > CNT_ONE) begin
          cnt_we_s          = 1'b1;
          cnt_wval_s        = cur_cnt_s - CNT_ONE;
          ack_nxt_s[port_r] = 1'b1;
          state_nxt_s       = ST_IDLE;
        end
`ifdef PKT_REFCNT_ERR_EN
        else if (cur_cnt_s == {REFCNT_W{1'b0}}) begin
          ack_nxt_s[port_r] = 1'b1;
          err_nxt_s         = 1'b1;
          state_nxt_s       = ST_IDLE;
        end
`endif
        else begin
          cnt_we_s          = 1'b1;
          ack_nxt_s[port_r] = 1'b1;
          free_wr_nxt_s     = 1'b1;
          free_bufid_nxt_s  = bufid_r;
          state_nxt_s       = ST_FREE;
        end
      end
      ST_FREE: begin
        if (i_free_bufid_ack) begin
          free_wr_nxt_s = 1'b0;
          state_nxt_s   = ST_IDLE;
        end else begin
          state_nxt_s = ST_FREE;
        end
      end
      default: begin
        free_wr_nxt_s = 1'b0;
        state_nxt_s   = ST_IDLE;
      end
    endcase
  end

  // FSM state, arbitration pointer, latched request and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r      <= ST_IDLE;
      last_r       <= 2'd3;
      port_r       <= 2'd0;
      bufid_r      <= 9'd0;
      ack_r        <= {PORT_NUM{1'b0}};
      free_wr_r    <= 1'b0;
      free_bufid_r <= 9'd0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      ack_r        <= ack_nxt_s;
      free_wr_r    <= free_wr_nxt_s;
      free_bufid_r <= free_bufid_nxt_s;
      err_r        <= err_nxt_s;
      if (latch_s) begin
        last_r  <= grant_port_s;
        port_r  <= grant_port_s;
        bufid_r <= iv_rel_bufid[sel_base_s +: 9];
      end else begin
        bufid_r <= bufid_r;
      end
    end
  end

  // Count array; the set strobe is written last so it overrides any FSM write to the same entry.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 512; i++) begin
        cnt_r[i] <= {REFCNT_W{1'b0}};
      end
    end else begin
      if (cnt_we_s) begin
        cnt_r[bufid_r] <= cnt_wval_s;
      end
      if (i_refcnt_wr) begin
        cnt_r[iv_refcnt_bufid] <= iv_refcnt_value;
      end
    end
  end

  assign ov_rel_bufid_ack   = ack_r;
  assign ov_free_bufid      = free_bufid_r;
  assign o_free_bufid_wr    = free_wr_r;
  assign o_refcnt_err_pulse = err_r;
  assign ov_rel_state       = state_r;

endmodule

// File: tb/tb_pkt_bufid_release.sv
// Self-checking bench for pkt_bufid_release: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.

module tb_pkt_bufid_release;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [8:0]  iv_refcnt_bufid;
  logic [3:0]  iv_refcnt_value;
  logic        i_refcnt_wr;
  logic [35:0] iv_rel_bufid;
  logic [3:0]  iv_rel_bufid_wr;
  logic [3:0]  ov_rel_bufid_ack;
  logic [8:0]  ov_free_bufid;
  logic        o_free_bufid_wr;
  logic        i_free_bufid_ack;
  logic        o_refcnt_err_pulse;
  logic [1:0]  ov_rel_state;

  pkt_bufid_release #(.REFCNT_W(4), .PORT_NUM(4)) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .iv_refcnt_bufid    (iv_refcnt_bufid),
    .iv_refcnt_value    (iv_refcnt_value),
    .i_refcnt_wr        (i_refcnt_wr),
    .iv_rel_bufid       (iv_rel_bufid),
    .iv_rel_bufid_wr    (iv_rel_bufid_wr),
    .ov_rel_bufid_ack   (ov_rel_bufid_ack),
    .ov_free_bufid      (ov_free_bufid),
    .o_free_bufid_wr    (o_free_bufid_wr),
    .i_free_bufid_ack   (i_free_bufid_ack),
    .o_refcnt_err_pulse (o_refcnt_err_pulse),
    .ov_rel_state       (ov_rel_state)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_log[$];
  int free_log[$];
  logic [3:0] renew;

  // Reference model: counts per bufid, which port is being served and what the outputs must show.
  int   m_cnt [512];
  int   m_ptr, m_mode, m_port, m_bufid;
  logic [3:0] e_ack;
  logic e_err, e_fwr;
  logic [8:0] e_fbuf;
  logic m_init = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model step per rising edge: mode 0 waiting for a request, 1 deciding, 2 handing to free list.
  always @(posedge i_clk) begin
    logic [3:0] cand;
    int p;
    int c;
    if (!i_rst_n) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_ptr = 3; m_mode = 0; m_port = 0; m_bufid = 0;
      e_ack = 4'b0; e_err = 1'b0; e_fwr = 1'b0; e_fbuf = 9'd0;
      m_init = 1'b1;
    end else begin
      cand  = iv_rel_bufid_wr & ~e_ack;
      e_ack = 4'b0;
      e_err = 1'b0;
      if (m_mode == 0) begin
        for (int k = 1; k <= 4; k++) begin
          p = (m_ptr + k) % 4;
          if (m_mode == 0 && cand[p]) begin
            m_port = p; m_bufid = int'(iv_rel_bufid[9*p +: 9]); m_ptr = p; m_mode = 1;
          end
        end
      end else if (m_mode == 1) begin
        if (!(i_refcnt_wr && int'(iv_refcnt_bufid) == m_bufid)) begin
          c = m_cnt[m_bufid];
          e_ack[m_port] = 1'b1;
          if (c >= 2) begin
            m_cnt[m_bufid] = c - 1; m_mode = 0;
          end
`ifdef PKT_REFCNT_ERR_EN
          else if (c == 0) begin
            e_err = 1'b1; m_mode = 0;
          end
`endif
          else begin
            m_cnt[m_bufid] = 0; e_fwr = 1'b1; e_fbuf = m_bufid[8:0]; m_mode = 2;
          end
        end
      end else begin
        if (i_free_bufid_ack) begin
          e_fwr = 1'b0; m_mode = 0;
        end
      end
      if (i_refcnt_wr) m_cnt[iv_refcnt_bufid] = int'(iv_refcnt_value);
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge i_clk) begin
    if (m_init) begin
      chk("cyc_ack", 32'(ov_rel_bufid_ack), 32'(e_ack));
      chk("cyc_free_wr", 32'(o_free_bufid_wr), 32'(e_fwr));
      chk("cyc_free_id", 32'(ov_free_bufid), 32'(e_fbuf));
      chk("cyc_err", 32'(o_refcnt_err_pulse), 32'(e_err));
      chk("cyc_state", 32'(ov_rel_state), 32'(m_mode));
    end
  end

  task automatic tick();
    logic fh;
    logic [8:0] fb;
    fh = o_free_bufid_wr & i_free_bufid_ack & i_rst_n;
    fb = ov_free_bufid;
    @(posedge i_clk);
    #1;
    if (fh === 1'b1) free_log.push_back(int'(fb));
    for (int k = 0; k < 4; k++) begin
      if (iv_rel_bufid_wr[k] && ov_rel_bufid_ack[k] === 1'b1) begin
        ack_log.push_back(k);
        if (!renew[k]) iv_rel_bufid_wr[k] = 1'b0;
      end
    end
  endtask

  task automatic set_cnt(input logic [8:0] b, input logic [3:0] v);
    iv_refcnt_bufid = b; iv_refcnt_value = v; i_refcnt_wr = 1'b1;
    tick();
    i_refcnt_wr = 1'b0;
  endtask

  task automatic release_req(input int port, input logic [8:0] b);
    iv_rel_bufid[9*port +: 9] = b;
    iv_rel_bufid_wr[port] = 1'b1;
  endtask

  task automatic wait_acks(input string name, input int n, input int budget);
    for (int t = 0; t < budget && ack_log.size() < n; t++) tick();
    chk(name, 32'(ack_log.size()), 32'(n));
  endtask

  initial begin
    int order35 [5];
    order35 = '{0, 1, 2, 3, 0};
    i_rst_n = 1'b0; iv_refcnt_bufid = 9'd0; iv_refcnt_value = 4'd0; i_refcnt_wr = 1'b0;
    iv_rel_bufid = 36'd0; iv_rel_bufid_wr = 4'b0; i_free_bufid_ack = 1'b0; renew = 4'b0;
    tick(); tick();
    i_rst_n = 1'b1;
    chk("rst_ack", 32'(ov_rel_bufid_ack), 32'h0);
    chk("rst_free_wr", 32'(o_free_bufid_wr), 32'h0);
    chk("rst_free_id", 32'(ov_free_bufid), 32'h0);
    chk("rst_err", 32'(o_refcnt_err_pulse), 32'h0);
    chk("rst_state", 32'(ov_rel_state), 32'h0);

    // Single release of a count-1 bufid.
    set_cnt(9'h005, 4'd1);
    release_req(0, 9'h005);
    tick();
    chk("t33_dec_state", 32'(ov_rel_state), 32'h1);
    chk("t33_no_early_ack", 32'(ov_rel_bufid_ack), 32'h0);
    tick();
    chk("t33_ack", 32'(ov_rel_bufid_ack), 32'h1);
    chk("t33_free_wr", 32'(o_free_bufid_wr), 32'h1);
    chk("t33_free_id", 32'(ov_free_bufid), 32'h005);
    tick();
    chk("t33_free_hold", 32'(o_free_bufid_wr), 32'h1);
    i_free_bufid_ack = 1'b1;
    tick();
    i_free_bufid_ack = 1'b0;
    chk("t33_free_done", 32'(o_free_bufid_wr), 32'h0);
    chk("t33_idle", 32'(ov_rel_state), 32'h0);
    chk("t33_cnt", 32'(dut.cnt_r[9'h005]), 32'h0);
    chk("t33_free_log", 32'(free_log.size()), 32'h1);

    // Three ports release one count-3 bufid together.
    ack_log.delete(); free_log.delete(); i_free_bufid_ack = 1'b1;
    set_cnt(9'h01A, 4'd3);
    release_req(1, 9'h01A); release_req(2, 9'h01A); release_req(3, 9'h01A);
    wait_acks("t34_acks", 3, 40);
    repeat (3) tick();
    if (ack_log.size() >= 3) begin
      for (int i = 0; i < 3; i++) chk("t34_order", 32'(ack_log[i]), 32'(i + 1));
    end
    chk("t34_one_free", 32'(free_log.size()), 32'h1);
    if (free_log.size() >= 1) chk("t34_free_id", 32'(free_log[0]), 32'h01A);
    chk("t34_model_cnt", 32'(m_cnt[9'h01A]), 32'h0);

    // All four ports request continuously.
    ack_log.delete(); free_log.delete();
    for (int k = 0; k < 4; k++) set_cnt(9'(9'h040 + k), 4'd2);
    renew = 4'hF;
    for (int k = 0; k < 4; k++) release_req(k, 9'(9'h040 + k));
    wait_acks("t35_acks", 5, 60);
    renew = 4'h0; iv_rel_bufid_wr = 4'b0;
    repeat (4) tick();
    if (ack_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("t35_rr", 32'(ack_log[i]), 32'(order35[i]));
    end
    chk("t35_free_log", 32'(free_log.size()), 32'h1);

    // Free-list back-pressure holds the FSM in FREE.
    i_free_bufid_ack = 1'b0; ack_log.delete();
    set_cnt(9'h078, 4'd2);
    set_cnt(9'h077, 4'd1);
    release_req(2, 9'h077);
    wait_acks("t36_ack", 1, 10);
    release_req(1, 9'h078);
    for (int t = 0; t < 10; t++) begin
      tick();
      chk("t36_wr_hold", 32'(o_free_bufid_wr), 32'h1);
      chk("t36_id_hold", 32'(ov_free_bufid), 32'h077);
      chk("t36_no_ack", 32'(ov_rel_bufid_ack), 32'h0);
    end
    i_free_bufid_ack = 1'b1;
    tick();
    chk("t36_released", 32'(o_free_bufid_wr), 32'h0);
    wait_acks("t36_drain", 2, 10);

    // Release of a never-set (zero-count) bufid.
    ack_log.delete(); free_log.delete();
    release_req(3, 9'h100);
    wait_acks("t37_ack", 1, 10);
`ifdef PKT_REFCNT_ERR_EN
    chk("t37_err", 32'(o_refcnt_err_pulse), 32'h1);
    chk("t37_no_free", 32'(o_free_bufid_wr), 32'h0);
    tick();
    chk("t37_err_one_cycle", 32'(o_refcnt_err_pulse), 32'h0);
    chk("t37_free_log", 32'(free_log.size()), 32'h0);
`else
    chk("t37_err", 32'(o_refcnt_err_pulse), 32'h0);
    chk("t37_free_wr", 32'(o_free_bufid_wr), 32'h1);
    chk("t37_free_id", 32'(ov_free_bufid), 32'h100);
    tick();
    chk("t37_free_log", 32'(free_log.size()), 32'h1);
`endif
    chk("t37_cnt", 32'(dut.cnt_r[9'h100]), 32'h0);

    // Reset while waiting in FREE.
    i_free_bufid_ack = 1'b0; ack_log.delete();
    set_cnt(9'h033, 4'd1);
    release_req(0, 9'h033);
    wait_acks("t38_ack", 1, 10);
    chk("t38_in_free", 32'(ov_rel_state), 32'h2);
    chk("t38_pre_cnt", 32'(dut.cnt_r[9'h041]), 32'h1);
    i_rst_n = 1'b0; iv_rel_bufid_wr = 4'b0;
    tick();
    chk("t38_ack", 32'(ov_rel_bufid_ack), 32'h0);
    chk("t38_free_wr", 32'(o_free_bufid_wr), 32'h0);
    chk("t38_free_id", 32'(ov_free_bufid), 32'h0);
    chk("t38_err", 32'(o_refcnt_err_pulse), 32'h0);
    chk("t38_state", 32'(ov_rel_state), 32'h0);
    chk("t38_cnt_clr", 32'(dut.cnt_r[9'h041]), 32'h0);
    i_rst_n = 1'b1;

    // Randomized traffic over a small bufid pool so sets collide with releases.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (!i_rst_n) i_rst_n = 1'b1;
      else if ($urandom_range(0, 499) == 0) begin
        i_rst_n = 1'b0; iv_rel_bufid_wr = 4'b0;
      end
      i_refcnt_wr      = ($urandom_range(0, 3) == 0);
      iv_refcnt_bufid  = 9'(9'h010 + $urandom_range(0, 7));
      iv_refcnt_value  = 4'($urandom_range(0, 3));
      i_free_bufid_ack = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) begin
        if (i_rst_n && !iv_rel_bufid_wr[k] && $urandom_range(0, 2) == 0)
          release_req(k, 9'(9'h010 + $urandom_range(0, 7)));
      end
    end
    i_refcnt_wr = 1'b0; iv_rel_bufid_wr = 4'b0; i_free_bufid_ack = 1'b1; i_rst_n = 1'b1;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
